// File: rtl/hx8347a_rx.sv
// hx8347a_rx: receives HX8347A-style 8080 bus writes (index/register/GRAM)
// and streams windowed RGB565 pixels into an Avalon-MM frame buffer.
module hx8347a_rx #(
    parameter int MEM_WIDTH  = 21,
    parameter int FB_BASE    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lcd_reset_n,
    input  logic                 lcd_cs,
    input  logic                 lcd_rs,
    input  logic [15:0]          lcd_data,
    input  logic                 lcd_write_n,
    input  logic                 lcd_read_n,
    output logic [MEM_WIDTH-1:0] fbuf_address,
    output logic                 fbuf_write,
    output logic [15:0]          fbuf_writedata,
    input  logic                 fbuf_waitrequest,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = MEM_WIDTH + 16;

    localparam logic [7:0]  IDX_GRAM  = 8'h22;
    localparam logic [8:0]  EC_RST    = 9'd319;
    localparam logic [8:0]  EP_RST    = 9'd239;
    localparam logic [19:0] SYNC_IDLE = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};

    typedef enum logic {B_IDLE, B_LOW} bus_state_t;
    typedef enum logic {M_IDLE, M_WRITE} m_state_t;

    logic unused_ok;
    assign unused_ok = &{1'b1, lcd_read_n};

    // Two-flop synchronizer: {lcd_reset_n, cs, rs, write_n, data}
    logic [19:0] sync1_q, sync2_q;
    logic        lcd_rst, cs_n_s, rs_s, wr_n_s;
    logic [15:0] data_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
        end else begin
            sync1_q <= {lcd_reset_n, lcd_cs, lcd_rs, lcd_write_n, lcd_data};
            sync2_q <= sync1_q;
        end
    end

    assign lcd_rst = ~sync2_q[19];
    assign cs_n_s  = sync2_q[18];
    assign rs_s    = sync2_q[17];
    assign wr_n_s  = sync2_q[16];
    assign data_s  = sync2_q[15:0];

    bus_state_t bus_state_q, bus_state_d;
    logic       rs_lat_q, rs_lat_d;
    logic [15:0] data_lat_q, data_lat_d;
    logic       commit;

    always_comb begin
        bus_state_d = bus_state_q;
        rs_lat_d    = rs_lat_q;
        data_lat_d  = data_lat_q;
        commit      = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                if (!wr_n_s && !cs_n_s) begin
                    bus_state_d = B_LOW;
                    rs_lat_d    = rs_s;
                    data_lat_d  = data_s;
                end
            end
            B_LOW: begin
                if (cs_n_s) begin
                    bus_state_d = B_IDLE;
                end else if (wr_n_s) begin
                    bus_state_d = B_IDLE;
                    commit      = 1'b1;
                end else begin
                    rs_lat_d   = rs_s;
                    data_lat_d = data_s;
                end
            end
            default: bus_state_d = B_IDLE;
        endcase
        if (lcd_rst) begin
            bus_state_d = B_IDLE;
            commit      = 1'b0;
        end
    end

    logic [7:0] index_q, index_d;
    logic [8:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [8:0] x_q, x_d, y_q, y_d;
    logic       frame_done_q, frame_done_d;
    logic       overflow_q, overflow_d;
    logic       push, pop, full, in_range;
    logic [MEM_WIDTH-1:0] pix_addr;

    // Y*320 as (Y<<8)+(Y<<6), wrapping at the memory address width.
    assign pix_addr = MEM_WIDTH'(FB_BASE) + MEM_WIDTH'({y_q, 8'd0})
                    + MEM_WIDTH'({y_q, 6'd0}) + MEM_WIDTH'(x_q);
    assign in_range = (x_q < 9'd320) && (y_q < 9'd240);

    always_comb begin
        index_d      = index_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        x_d          = x_q;
        y_d          = y_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        if (commit && !rs_lat_q) begin
            index_d = data_lat_q[7:0];
            if (data_lat_q[7:0] == IDX_GRAM) begin
                x_d = sc_q;
                y_d = sp_q;
            end
        end else if (commit) begin
            case (index_q)
                8'h02: sc_d[8]   = data_lat_q[0];
                8'h03: sc_d[7:0] = data_lat_q[7:0];
                8'h04: ec_d[8]   = data_lat_q[0];
                8'h05: ec_d[7:0] = data_lat_q[7:0];
                8'h06: sp_d[8]   = data_lat_q[0];
                8'h07: sp_d[7:0] = data_lat_q[7:0];
                8'h08: ep_d[8]   = data_lat_q[0];
                8'h09: ep_d[7:0] = data_lat_q[7:0];
                IDX_GRAM: begin
                    // Off-screen and dropped pixels still move the cursor.
                    if (in_range) begin
                        if (full) overflow_d = 1'b1;
                        else      push       = 1'b1;
                    end
                    if (x_q != ec_q) begin
                        x_d = x_q + 9'd1;
                    end else begin
                        x_d = sc_q;
                        if (y_q != ep_q) begin
                            y_d = y_q + 9'd1;
                        end else begin
                            y_d          = sp_q;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (lcd_rst) begin
            index_d      = 8'h00;
            sc_d         = 9'd0;
            ec_d         = EC_RST;
            sp_d         = 9'd0;
            ep_d         = EP_RST;
            x_d          = 9'd0;
            y_d          = 9'd0;
            overflow_d   = 1'b0;
            frame_done_d = 1'b0;
            push         = 1'b0;
        end
    end

    // Write queue and Avalon master
    logic [ENT_W-1:0]     fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [CNT_W-1:0]     count_q, count_d;
    m_state_t             m_state_q, m_state_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        m_state_d = m_state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pop       = 1'b0;
        case (m_state_q)
            M_IDLE: begin
                if (count_q != '0 && !lcd_rst) begin
                    m_state_d         = M_WRITE;
                    {addr_d, wdata_d} = fifo_q[rd_ptr_q];
                end
            end
            M_WRITE: begin
                if (!fbuf_waitrequest) begin
                    pop = 1'b1;
                    if (count_q > CNT_W'(1) && !lcd_rst) begin
                        {addr_d, wdata_d} = fifo_q[rd_next];
                    end else begin
                        m_state_d = M_IDLE;
                    end
                end
            end
            default: m_state_d = M_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Panel reset flushes everything except a write already on the bus.
        if (lcd_rst) begin
            if (m_state_q == M_WRITE && !pop) begin
                wr_ptr_d = rd_next;
                count_d  = CNT_W'(1);
            end else begin
                wr_ptr_d = rd_ptr_d;
                count_d  = '0;
            end
            if (m_state_d == M_IDLE) begin
                addr_d  = '0;
                wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {pix_addr, data_lat_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_state_q  <= B_IDLE;
            rs_lat_q     <= 1'b0;
            data_lat_q   <= 16'h0000;
            index_q      <= 8'h00;
            sc_q         <= 9'd0;
            ec_q         <= EC_RST;
            sp_q         <= 9'd0;
            ep_q         <= EP_RST;
            x_q          <= 9'd0;
            y_q          <= 9'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            m_state_q    <= M_IDLE;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
        end else begin
            bus_state_q  <= bus_state_d;
            rs_lat_q     <= rs_lat_d;
            data_lat_q   <= data_lat_d;
            index_q      <= index_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            m_state_q    <= m_state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign fbuf_write     = (m_state_q == M_WRITE);
    assign fbuf_address   = addr_q;
    assign fbuf_writedata = wdata_q;
    assign frame_done     = frame_done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_hx8347a_rx.sv
// Randomized bench for hx8347a_rx: drives 8080 bus writes and checks the
// Avalon write stream against a window/cursor reference model.
`timescale 1ns/1ps
module tb_hx8347a_rx;
    localparam int MEM_WIDTH  = 21;
    localparam int FB_BASE    = 1000;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset_n, lcd_reset_n, lcd_cs, lcd_rs, lcd_write_n, lcd_read_n;
    logic [15:0]          lcd_data;
    logic [MEM_WIDTH-1:0] fbuf_address;
    logic                 fbuf_write, fbuf_waitrequest, frame_done, overflow;
    logic [15:0]          fbuf_writedata;

    hx8347a_rx #(.MEM_WIDTH(MEM_WIDTH), .FB_BASE(FB_BASE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_reset_n(lcd_reset_n), .lcd_cs(lcd_cs),
        .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_write_n(lcd_write_n),
        .lcd_read_n(lcd_read_n), .fbuf_address(fbuf_address), .fbuf_write(fbuf_write),
        .fbuf_writedata(fbuf_writedata), .fbuf_waitrequest(fbuf_waitrequest),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int acc_cnt = 0, frame_cnt = 0, frame_exp = 0;
    int wait_mode = 0;  // 0 none, 1 random stalls, 2 held high
    int unsigned exp_a[$];
    int unsigned exp_d[$];
    int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_idx;
    bit m_ovf;
    logic prev_stall = 1'b0;
    logic [MEM_WIDTH-1:0] prev_a;
    logic [15:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
        m_x = 0; m_y = 0; m_idx = 0; m_ovf = 0;
    endtask

    task automatic model_pixel(input logic [15:0] d);
        if (m_x < 320 && m_y < 240) begin
            if (exp_a.size() < FIFO_DEPTH) begin
                exp_a.push_back((FB_BASE + m_y * 320 + m_x) % (1 << MEM_WIDTH));
                exp_d.push_back(int'(d));
            end else begin
                m_ovf = 1;
            end
        end
        if (m_x != m_ec) m_x = (m_x + 1) % 512;
        else begin
            m_x = m_sc;
            if (m_y != m_ep) m_y = (m_y + 1) % 512;
            else begin
                m_y = m_sp;
                frame_exp++;
            end
        end
    endtask

    task automatic model_write(input bit rs, input logic [15:0] d);
        int hi, lo;
        hi = d[0] ? 256 : 0;
        lo = int'(d[7:0]);
        if (!rs) begin
            m_idx = lo;
            if (m_idx == 'h22) begin m_x = m_sc; m_y = m_sp; end
        end else begin
            case (m_idx)
                'h02: m_sc = (m_sc % 256) + hi;
                'h03: m_sc = (m_sc / 256) * 256 + lo;
                'h04: m_ec = (m_ec % 256) + hi;
                'h05: m_ec = (m_ec / 256) * 256 + lo;
                'h06: m_sp = (m_sp % 256) + hi;
                'h07: m_sp = (m_sp / 256) * 256 + lo;
                'h08: m_ep = (m_ep % 256) + hi;
                'h09: m_ep = (m_ep / 256) * 256 + lo;
                'h22: model_pixel(d);
                default: ;
            endcase
        end
    endtask

    task automatic bus_wr(input bit rs, input logic [15:0] d);
        model_write(rs, d);
        @(posedge clk);
        lcd_cs = 1'b0; lcd_rs = rs; lcd_data = d; lcd_write_n = 1'b0;
        repeat (3) @(posedge clk);
        lcd_write_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic set_reg(input logic [7:0] idx, input logic [15:0] d);
        bus_wr(1'b0, {8'h00, idx});
        bus_wr(1'b1, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || fbuf_write) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_bound", 32'(n < 2000), 1);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_cnt", frame_cnt, frame_exp);
    endtask

    // Avalon slave side: sets waitrequest on the falling edge and predicts
    // the transfer that the next rising edge will accept.
    initial begin
        fbuf_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            case (wait_mode)
                0:       fbuf_waitrequest = 1'b0;
                1:       fbuf_waitrequest = ($urandom_range(0, 3) == 0);
                default: fbuf_waitrequest = 1'b1;
            endcase
            if (reset_n) begin
                if (frame_done) frame_cnt++;
                if (fbuf_write && prev_stall) begin
                    chk("stable_addr", 32'(fbuf_address), 32'(prev_a));
                    chk("stable_data", 32'(fbuf_writedata), 32'(prev_d));
                end
                prev_stall = fbuf_write && fbuf_waitrequest;
                prev_a = fbuf_address;
                prev_d = fbuf_writedata;
                if (fbuf_write && !fbuf_waitrequest) begin
                    acc_cnt++;
                    if (exp_a.size() == 0) begin
                        chk("spurious_write", 32'(fbuf_address), 32'hFFFF_FFFF);
                    end else begin
                        chk("wr_addr", 32'(fbuf_address), exp_a.pop_front());
                        chk("wr_data", 32'(fbuf_writedata), exp_d.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int idx_tab[10];
        logic [7:0] idx;
        idx_tab = '{2, 3, 4, 5, 6, 7, 8, 9, 'h10, 'h22};
        model_reset();
        reset_n = 1'b0; lcd_reset_n = 1'b1; lcd_cs = 1'b1; lcd_rs = 1'b0;
        lcd_write_n = 1'b1; lcd_read_n = 1'b1; lcd_data = 16'h0000;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_write", 32'(fbuf_write), 0);
        chk("rst_addr", 32'(fbuf_address), 0);
        chk("rst_data", 32'(fbuf_writedata), 0);
        chk("rst_frame", 32'(frame_done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        repeat (4) @(posedge clk);

        // Default window: two pixels at the base address.
        bus_wr(1'b0, 16'h0022);
        bus_wr(1'b1, 16'hF800);
        bus_wr(1'b1, 16'h07E0);
        drain();

        // 16x16 window, one full frame with random stalls.
        wait_mode = 1;
        set_reg(8'h02, 16'h0000); set_reg(8'h03, 16'h0010);
        set_reg(8'h04, 16'h0000); set_reg(8'h05, 16'h001F);
        set_reg(8'h06, 16'h0000); set_reg(8'h07, 16'h0008);
        set_reg(8'h08, 16'h0000); set_reg(8'h09, 16'h0017);
        bus_wr(1'b0, 16'h0022);
        for (int i = 0; i < 256; i++) begin
            bus_wr(1'b1, 16'($urandom));
            #1;
            chk("frame_progress", frame_cnt, frame_exp);
        end
        chk("frame_once", frame_cnt, 1);
        bus_wr(1'b1, 16'h5A5A);
        drain();

        // Held waitrequest: queue fills, the rest is dropped.
        wait_mode = 2;
        acc0 = acc_cnt;
        bus_wr(1'b0, 16'h0022);
        for (int i = 0; i < 10; i++) bus_wr(1'b1, 16'h1000 + 16'(i));
        repeat (112) @(posedge clk);
        #1;
        chk("hold_no_accept", acc_cnt - acc0, 0);
        chk("hold_ovf", 32'(overflow), 1);
        chk("hold_write_req", 32'(fbuf_write), 1);
        wait_mode = 0;
        drain();
        chk("hold_retained", acc_cnt - acc0, FIFO_DEPTH);

        // Window straddling the right edge.
        acc0 = acc_cnt;
        set_reg(8'h02, 16'h0001); set_reg(8'h03, 16'h003E);
        set_reg(8'h04, 16'h0001); set_reg(8'h05, 16'h0041);
        set_reg(8'h06, 16'h0000); set_reg(8'h07, 16'h0000);
        set_reg(8'h08, 16'h0000); set_reg(8'h09, 16'h00EF);
        bus_wr(1'b0, 16'h0022);
        for (int i = 0; i < 4; i++) bus_wr(1'b1, 16'h2000 + 16'(i));
        drain();
        chk("edge_writes", acc_cnt - acc0, 2);

        // Chip select dropped mid-strobe aborts the pixel.
        acc0 = acc_cnt;
        @(posedge clk);
        lcd_cs = 1'b0; lcd_rs = 1'b1; lcd_data = 16'hABCD; lcd_write_n = 1'b0;
        repeat (3) @(posedge clk);
        lcd_cs = 1'b1;
        repeat (3) @(posedge clk);
        lcd_write_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_write", acc_cnt - acc0, 0);
        bus_wr(1'b1, 16'h1234);
        drain();
        chk("abort_next", acc_cnt - acc0, 1);

        // Panel reset during a stalled burst.
        wait_mode = 2;
        acc0 = acc_cnt;
        bus_wr(1'b0, 16'h0022);
        for (int i = 0; i < 3; i++) bus_wr(1'b1, 16'h3000 + 16'(i));
        lcd_reset_n = 1'b0;
        repeat (6) @(posedge clk);
        lcd_reset_n = 1'b1;
        while (exp_a.size() > 1) void'(exp_a.pop_back());
        while (exp_d.size() > 1) void'(exp_d.pop_back());
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("lcdrst_ovf", 32'(overflow), 0);
        chk("lcdrst_inflight", 32'(fbuf_write), 1);
        wait_mode = 0;
        drain();
        chk("lcdrst_writes", acc_cnt - acc0, 1);
        bus_wr(1'b0, 16'h0022);
        bus_wr(1'b1, 16'h4321);
        bus_wr(1'b1, 16'h8765);
        drain();

        // Random register/index/pixel traffic.
        wait_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = ($urandom_range(0, 1) == 0) ? 8'h22 : 8'(idx_tab[$urandom_range(0, 9)]);
                bus_wr(1'b0, {8'($urandom), idx});
            end else begin
                bus_wr(1'b1, 16'($urandom));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
